// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed 7-segment scanner with frame-synchronous double buffering.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module display_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    output logic        sel_b,
    output logic        sel_a,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [111:0] SEG = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    state_t state;
    logic [PW-1:0] presc;
    logic [1:0] idx;
    logic [15:0] shadow, pending;
    logic [3:0] shadowDp, pendingDp;
    logic pendVld;
    logic [3:0] nib;
    logic lz;
    logic [6:0] glyph;
    logic boundary;
    logic accept;
    assign sel_b = idx[1];
    assign sel_a = idx[0];
    always_comb begin
        nib = 4'(shadow >> {idx, 2'b00});
`ifdef LEADING_ZERO_BLANK_EN
        lz = idx != 2'd0 && (shadow >> {idx, 2'b00}) == 16'd0;
`else
        lz = 1'b0;
`endif
        glyph = lz ? 7'h7F : SEG[int'(nib)*7 +: 7];
        boundary = en && state == SHOW && presc == PW'(CLK_DIV - 1) && idx == 2'd3;
        accept = wr_valid && wr_ready;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            idx        <= 2'd0;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            wr_ready   <= 1'b1;
            frame_done <= 1'b0;
            shadow     <= 16'd0;
            shadowDp   <= 4'd0;
            pending    <= 16'd0;
            pendingDp  <= 4'd0;
            pendVld    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!en) begin
                state <= IDLE;
                presc <= '0;
                idx   <= 2'd0;
                seg_n <= 7'h7F;
                dp_n  <= 1'b1;
            end else if (state == IDLE) begin
                state <= BLANK;
                presc <= '0;
                idx   <= 2'd0;
            end else if (state == BLANK) begin
                presc <= presc + 1'b1;
                if (presc == PW'(BLANK_CYC - 1)) begin
                    state <= SHOW;
                    seg_n <= glyph;
                    dp_n  <= ~shadowDp[idx];
                end
            end else if (presc == PW'(CLK_DIV - 1)) begin
                state      <= BLANK;
                presc      <= '0;
                idx        <= idx + 1'b1;
                seg_n      <= 7'h7F;
                dp_n       <= 1'b1;
                frame_done <= idx == 2'd3;
            end else begin
                presc <= presc + 1'b1;
                seg_n <= glyph;
                dp_n  <= ~shadowDp[idx];
            end
            // IDLE behaves as a frame boundary so a value left pending by en=0 is not stranded
            if ((state == IDLE || boundary) && pendVld) begin
                shadow   <= pending;
                shadowDp <= pendingDp;
                pendVld  <= 1'b0;
                wr_ready <= 1'b1;
            end
            if (accept) begin
                if (state == IDLE) begin
                    shadow   <= wr_data;
                    shadowDp <= wr_dp;
                end else begin
                    pending   <= wr_data;
                    pendingDp <= wr_dp;
                    pendVld   <= 1'b1;
                    wr_ready  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed + random stimulus against a cycle-count based display model.
module tb_display_scan_ctrl;
    localparam int CD = 4;
    localparam int BC = 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic wr_valid = 1'b0;
    logic wr_ready;
    logic [15:0] wr_data = 16'd0;
    logic [3:0] wr_dp = 4'd0;
    logic sel_b, sel_a, dp_n, frame_done;
    logic [6:0] seg_n;
    int checks = 0;
    int failures = 0;
    bit mRun, mPendVld, mReady;
    int c;
    logic [15:0] mShadow, mPend;
    logic [3:0] mShadowDp, mPendDp;
    logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    display_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_dp(wr_dp), .sel_b(sel_b), .sel_a(sel_a),
        .seg_n(seg_n), .dp_n(dp_n), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [15:0] v, input int s);
        logic [15:0] u = v >> (4 * s);
`ifdef LEADING_ZERO_BLANK_EN
        if (s != 0 && u == 16'd0) return 7'h7F;
`endif
        return segTab[u[3:0]];
    endfunction

    task automatic modelReset();
        mRun = 0; c = 0; mPendVld = 0; mReady = 1;
        mShadow = 0; mPend = 0; mShadowDp = 0; mPendDp = 0;
    endtask

    // Slot = c/CD, offset in slot = c%CD; the first BC cycles of every slot are dark.
    task automatic checkOutputs();
        int slot = (c / CD) % 4;
        int off = c % CD;
        bit lit = mRun && off >= BC;
        logic [1:0] s2 = slot[1:0];
        check("sel", {14'd0, sel_b, sel_a}, mRun ? {14'd0, s2} : 16'd0);
        check("seg", {9'd0, seg_n}, lit ? {9'd0, glyph(mShadow, slot)} : 16'h7F);
        check("dp", {15'd0, dp_n}, lit ? {15'd0, !mShadowDp[slot]} : 16'd1);
        check("ready", {15'd0, wr_ready}, {15'd0, mReady});
        check("frame_done", {15'd0, frame_done}, {15'd0, mRun && c > 0 && c % (4 * CD) == 0});
    endtask

    task automatic tick();
        bit wasIdle = !mRun;
        bit acc = wr_valid && mReady;
        bit bnd = 0;
        @(posedge clk);
        #1;
        if (!en) mRun = 0;
        else if (!mRun) begin mRun = 1; c = 0; end
        else begin c++; bnd = c % (4 * CD) == 0; end
        if ((wasIdle || bnd) && mPendVld) begin
            mShadow = mPend; mShadowDp = mPendDp; mPendVld = 0; mReady = 1;
        end
        if (acc) begin
            if (wasIdle) begin mShadow = wr_data; mShadowDp = wr_dp; end
            else begin mPend = wr_data; mPendDp = wr_dp; mPendVld = 1; mReady = 0; end
        end
        checkOutputs();
    endtask

    task automatic asyncReset();
        #2 rst = 1'b1;
        #1;
        modelReset();
        check("rst_seg", {9'd0, seg_n}, 16'h7F);
        check("rst_dp", {15'd0, dp_n}, 16'd1);
        check("rst_sel", {14'd0, sel_b, sel_a}, 16'd0);
        check("rst_ready", {15'd0, wr_ready}, 16'd1);
        check("rst_fd", {15'd0, frame_done}, 16'd0);
        rst = 1'b0;
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutputs();
        rst = 1'b0;
        // value written while idle is displayed from the first frame
        wr_valid = 1; wr_data = 16'h1234; wr_dp = 4'b0101;
        tick();
        wr_valid = 0; en = 1;
        repeat (40) tick();
        // mid-frame write waits for the boundary
        wr_valid = 1; wr_data = 16'hABCD; wr_dp = 4'b1000;
        tick();
        wr_valid = 0;
        repeat (40) tick();
        // write accepted on the boundary edge itself
        for (int i = 0; i < 20 && (c + 1) % (4 * CD) != 0; i++) tick();
        wr_valid = 1; wr_data = 16'h5678; wr_dp = 4'b0011;
        tick();
        wr_data = 16'h9EF0;
        for (int i = 0; i < 40 && !mReady; i++) tick();
        tick();
        wr_valid = 0;
        repeat (40) tick();
        // drop enable mid-slot with a pending value
        repeat (5) tick();
        wr_valid = 1; wr_data = 16'h0C0D; wr_dp = 4'b0100;
        tick();
        wr_valid = 0; en = 0;
        tick();
        en = 1;
        repeat (24) tick();
        // reset during SHOW with a pending value
        wr_valid = 1; wr_data = 16'h4321;
        tick();
        wr_valid = 0;
        repeat (2) tick();
        asyncReset();
        repeat (20) tick();
        // leading zeros
        en = 0;
        repeat (2) tick();
        wr_valid = 1; wr_data = 16'h0050; wr_dp = 4'b0000;
        tick();
        wr_valid = 0; en = 1;
        repeat (20) tick();
        for (int i = 0; i < 2000; i++) begin
            en = $urandom_range(0, 39) != 0;
            wr_valid = $urandom_range(0, 5) == 0;
            wr_data = 16'($urandom) >> (4 * $urandom_range(0, 4));
            wr_dp = 4'($urandom);
            tick();
            if ($urandom_range(0, 299) == 0) asyncReset();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
